// File: rtl/blake_pkg.sv
// Shared BLAKE header-block constants for the loader, message mux and core.
package blake_pkg;
  localparam int WORD_W    = 64;
  localparam int MSG_WORDS = 10;
  localparam int MSG_W     = WORD_W * MSG_WORDS;
  localparam int BLK_CNT_W = 16;

  typedef logic [BLK_CNT_W-1:0] blk_cnt_t;
endpackage

// File: rtl/blake_msg_loader_if.sv
// Word stream in, block handoff to the core out.
interface blake_msg_loader_if #(
  parameter int WORD_W = blake_pkg::WORD_W,
  parameter int MSG_W  = blake_pkg::MSG_W
);
  logic [WORD_W-1:0]             s_data;
  logic                          s_valid;
  logic                          s_last;
  logic                          s_ready;
  logic [MSG_W-1:0]              msg_out;
  logic                          core_start;
  logic                          core_done;
  logic                          err_len;
  logic [blake_pkg::BLK_CNT_W-1:0] blk_cnt;

  modport slave (
    input  s_data, s_valid, s_last, core_done,
    output s_ready, msg_out, core_start, err_len, blk_cnt
  );

  modport master (
    output s_data, s_valid, s_last, core_done,
    input  s_ready, msg_out, core_start, err_len, blk_cnt
  );
endinterface

// File: rtl/blake_msg_fill.sv
// Fill side: collects words into the staging buffer and checks block length.
module blake_msg_fill #(
  parameter int WORD_W    = blake_pkg::WORD_W,
  parameter int MSG_WORDS = blake_pkg::MSG_WORDS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WORD_W-1:0]                 s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  input  logic                              take,
  output logic                              s_ready,
  output logic [MSG_WORDS-1:0][WORD_W-1:0]  fill_buf,
  output logic                              fill_full,
  output logic                              err_len
);
  import blake_pkg::*;

  localparam int CNT_W = $clog2(MSG_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_WORDS - 1);

  logic [CNT_W-1:0] fill_cnt;
  logic             xfer;

  assign s_ready = ~fill_full;
  assign xfer    = s_valid & ~fill_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (take) fill_full <= 1'b0;
      if (xfer) begin
        // Any s_last misplacement drops the partial block; its words get overwritten.
        if (fill_cnt == LAST) begin
          fill_cnt <= '0;
          if (s_last) fill_full <= 1'b1;
          else        err_len   <= 1'b1;
        end else if (s_last) begin
          fill_cnt <= '0;
          err_len  <= 1'b1;
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  // Word 0 lands in the most significant slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_buf <= '0;
    end else if (xfer) begin
      for (int w = 0; w < MSG_WORDS; w++)
        if (fill_cnt == CNT_W'(w)) fill_buf[MSG_WORDS-1-w] <= s_data;
    end
  end
endmodule

// File: rtl/blake_msg_loader.sv
// Double-buffered message loader: fills one block while the core works on another.
module blake_msg_loader #(
  parameter int WORD_W    = blake_pkg::WORD_W,
  parameter int MSG_WORDS = blake_pkg::MSG_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  blake_msg_loader_if.slave  bus
);
  import blake_pkg::*;

  localparam int MW = WORD_W * MSG_WORDS;

  typedef enum logic {IDLE, RUN} state_e;

  logic [MSG_WORDS-1:0][WORD_W-1:0] fill_buf;
  logic                             fill_full;
  logic                             swap;
  state_e                           state;
  logic [MW-1:0]                    msg_q;
  logic                             start_q;
  blk_cnt_t                         blk_cnt_q;

  blake_msg_fill #(.WORD_W(WORD_W), .MSG_WORDS(MSG_WORDS)) u_fill (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (bus.s_data),
    .s_valid  (bus.s_valid),
    .s_last   (bus.s_last),
    .take     (swap),
    .s_ready  (bus.s_ready),
    .fill_buf (fill_buf),
    .fill_full(fill_full),
    .err_len  (bus.err_len)
  );

  // Swap depends only on registered state, so core_done never reaches outputs combinationally.
  assign swap = fill_full && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      msg_q     <= '0;
      start_q   <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      start_q <= swap;
      case (state)
        IDLE: if (swap) begin
          msg_q     <= fill_buf;
          blk_cnt_q <= blk_cnt_q + 1'b1;
          state     <= RUN;
        end
        RUN:  if (bus.core_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.msg_out    = msg_q;
  assign bus.core_start = start_q;
  assign bus.blk_cnt    = blk_cnt_q;
endmodule

// File: tb/tb_blake_msg_loader.sv
// Directed bench for blake_msg_loader: handoff timing, double buffering, length errors, reset.
module tb_blake_msg_loader;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  blake_msg_loader_if bus ();

  blake_msg_loader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [639:0] mk(input logic [31:0] tag);
    logic [639:0] m;
    m = '0;
    for (int i = 0; i < 10; i++) m[639-64*i -: 64] = {tag, 32'(i)};
    return m;
  endfunction

  // Present one word and wait for the edge that takes it; leaves s_valid high.
  task automatic push(input logic [63:0] d, input logic l);
    int t;
    t = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && t < 1000) begin
      step(1);
      t++;
    end
    chk("push_ready", bus.s_ready, 1);
    step(1);
  endtask

  task automatic send_block(input logic [31:0] tag);
    for (int i = 0; i < 10; i++) push({tag, 32'(i)}, i == 9);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic done_pulse();
    bus.core_done = 1'b1;
    step(1);
    bus.core_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.core_done = 1'b0;
    rst_n         = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_msg", bus.msg_out, '0);
    chk("rst_start", bus.core_start, 0);
    chk("rst_err", bus.err_len, 0);
    chk("rst_blk", bus.blk_cnt, 0);

    // Block A: words 0..9, started from IDLE
    send_block(32'h0);
    chk("a_start_early", bus.core_start, 0);
    chk("a_full_ready", bus.s_ready, 0);
    step(1);
    chk("a_start", bus.core_start, 1);
    chk("a_msg", bus.msg_out, mk(32'h0));
    chk("a_msg_hi", bus.msg_out[639:576], 64'd0);
    chk("a_msg_lo", bus.msg_out[63:0], 64'd9);
    chk("a_blk", bus.blk_cnt, 1);
    chk("a_ready", bus.s_ready, 1);
    step(1);
    chk("a_start_once", bus.core_start, 0);

    // Block B streamed while A runs
    send_block(32'hB);
    chk("b_wait_ready", bus.s_ready, 0);
    step(3);
    chk("b_hold_msg", bus.msg_out, mk(32'h0));
    chk("b_hold_start", bus.core_start, 0);
    chk("b_hold_ready", bus.s_ready, 0);
    done_pulse();
    chk("b_gap_start", bus.core_start, 0);
    chk("b_gap_msg", bus.msg_out, mk(32'h0));
    step(1);
    chk("b_start", bus.core_start, 1);
    chk("b_msg", bus.msg_out, mk(32'hB));
    chk("b_blk", bus.blk_cnt, 2);
    chk("b_ready", bus.s_ready, 1);
    step(1);
    done_pulse();

    // s_last on word 4
    for (int i = 0; i < 5; i++) push({32'hE, 32'(i)}, i == 4);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("short_err", bus.err_len, 1);
    chk("short_ready", bus.s_ready, 1);
    step(1);
    chk("short_err_once", bus.err_len, 0);
    chk("short_no_start", bus.core_start, 0);
    step(2);
    chk("short_no_start2", bus.core_start, 0);
    chk("short_blk", bus.blk_cnt, 2);
    send_block(32'hC);
    step(1);
    chk("c_start", bus.core_start, 1);
    chk("c_msg", bus.msg_out, mk(32'hC));
    chk("c_blk", bus.blk_cnt, 3);
    done_pulse();

    // Ten words without s_last
    for (int i = 0; i < 10; i++) push({32'hF, 32'(i)}, 1'b0);
    bus.s_valid = 1'b0;
    chk("nolast_err", bus.err_len, 1);
    chk("nolast_ready", bus.s_ready, 1);
    chk("nolast_cnt", dut.u_fill.fill_cnt, 0);
    step(1);
    chk("nolast_err_once", bus.err_len, 0);
    chk("nolast_no_start", bus.core_start, 0);
    chk("nolast_ready2", bus.s_ready, 1);
    chk("nolast_blk", bus.blk_cnt, 3);

    // Reset mid-block
    for (int i = 0; i < 5; i++) push({32'h5, 32'(i)}, 1'b0);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rst1_msg", bus.msg_out, '0);
    chk("rst1_blk", bus.blk_cnt, 0);
    chk("rst1_ready", bus.s_ready, 1);
    chk("rst1_start", bus.core_start, 0);
    chk("rst1_err", bus.err_len, 0);
    send_block(32'hD);
    step(1);
    chk("d_start", bus.core_start, 1);
    chk("d_msg", bus.msg_out, mk(32'hD));
    chk("d_blk", bus.blk_cnt, 1);

    // Reset during RUN, then a stray core_done
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst2_msg", bus.msg_out, '0);
    chk("rst2_blk", bus.blk_cnt, 0);
    chk("rst2_start", bus.core_start, 0);
    chk("rst2_ready", bus.s_ready, 1);
    done_pulse();
    step(2);
    chk("rst2_no_start", bus.core_start, 0);
    chk("rst2_blk_after_done", bus.blk_cnt, 0);
    chk("rst2_err", bus.err_len, 0);

    // Back-to-back: 16 blocks, s_valid held high, core_done 20 cycles after each start
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    fork
      begin
        for (int b = 0; b < 16; b++)
          for (int i = 0; i < 10; i++) push({32'h100 + 32'(b), 32'(i)}, i == 9);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end
      begin
        for (int b = 0; b < 16; b++) begin
          int t;
          t = 0;
          while (!bus.core_start && t < 500) begin
            step(1);
            t++;
          end
          chk("bb_start_seen", bus.core_start, 1);
          chk("bb_msg", bus.msg_out, mk(32'h100 + 32'(b)));
          chk("bb_blk", bus.blk_cnt, 16'(b + 1));
          step(19);
          chk("bb_msg_hold", bus.msg_out, mk(32'h100 + 32'(b)));
          done_pulse();
        end
      end
    join
    step(3);
    chk("bb_blk_final", bus.blk_cnt, 16);
    chk("bb_no_extra_start", bus.core_start, 0);
    chk("bb_ready_final", bus.s_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blake_msg_loader.md
BLAKE_MSG_LOADER -- requirements
Module: blake_msg_loader

Interface
REQ-001 Parameter WORD_W, default 64: message word width in bits.
REQ-002 Parameter MSG_WORDS, default 10: words per 640-bit header block.
REQ-003 The module SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
REQ-004 The module SHALL provide these data ports:
- s_data  in  64  incoming message word.
- s_valid  in  1  s_data is valid.
- s_last  in  1  marks the final word of a block.
- s_ready  out  1  loader can accept a word.
- msg_out  out  640  active block, presented to the message mux.
- core_start  out  1  one-cycle pulse: a new block is on msg_out.
- core_done  in  1  one-cycle pulse: the core has finished with msg_out.
- err_len  out  1  one-cycle pulse: a malformed block was discarded.
- blk_cnt  out  16  number of blocks started.

Function
REQ-005 A word SHALL transfer only on a rising edge where s_valid=1 and s_ready=1.
REQ-006 Accepted word i (0..9) SHALL be stored at fill-buffer bits [639-64i : 576-64i]; word 0 is the MSB word.
REQ-007 fill_cnt SHALL count 0..9 and increment on each transfer.
REQ-008 Accepting word 9 together with s_last=1 SHALL set fill_full and reset fill_cnt to 0.
REQ-009 s_ready SHALL equal !fill_full; no word is accepted while a full block waits.
REQ-010 If s_last=1 on a word with fill_cnt≠9, or word 9 arrives with s_last=0, the loader SHALL:
- pulse err_len high for one cycle on the next edge;
- reset fill_cnt to 0;
- leave fill_full at 0 and discard the partial block.
REQ-011 Active side states: IDLE (busy=0) and RUN (busy=1).
REQ-012 On an edge where fill_full=1 and busy=0, the loader SHALL:
- copy the fill buffer to msg_out;
- set busy=1 and clear fill_full;
- drive core_start=1 for exactly the following cycle;
- increment blk_cnt modulo 2^16.
REQ-013 msg_out SHALL remain constant from core_start until the edge that captures core_done in RUN.
REQ-014 core_done captured in RUN SHALL set busy=0. core_done in IDLE SHALL be ignored.
REQ-015 Simultaneous core_done and fill_full=1 while busy: busy clears on that edge, and the swap occurs on the next edge. The minimum gap between core_done and core_start is therefore two cycles.
REQ-016 Filling SHALL proceed while in RUN (double buffering). At most one full block waits.
REQ-017 Latency: the edge accepting word 9 sets fill_full; if IDLE, the next edge swaps; core_start is high in the cycle after that swap.
REQ-018 Padding and sigma ordering SHALL NOT be applied here; msg_out carries the raw 640 bits.

Reset
REQ-019 On rst_n=0 at a clock edge, the following SHALL be cleared: fill_cnt=0, fill_full=0, busy=0, msg_out=0, fill buffer=0, core_start=0, err_len=0, blk_cnt=0.
REQ-020 s_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-021 Reset mid-block or mid-RUN SHALL abandon all data; no core_start or err_len pulse is generated for abandoned data.

Structure
REQ-022 Package blake_pkg SHALL hold WORD_W, MSG_WORDS and MSG_W=640, shared with the message mux and the core.
REQ-023 Sub-module blake_msg_fill SHALL own the fill buffer, fill_cnt, the s_last/length check and fill_full. The top level owns busy, msg_out, core_start and blk_cnt.
REQ-024 The design SHALL contain no combinational path from s_valid or core_done to any output except s_ready.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Words 0x0000..0009 (word i = i), s_last on word 9, IDLE -> core_start one cycle later than the swap edge; msg_out[639:576]=0, msg_out[63:0]=9; blk_cnt=1.
- Block B streamed during RUN of block A -> msg_out stays A until core_done; s_ready=0 after B's word 9; B starts two cycles after core_done; blk_cnt=2.
- s_last on word 4 -> err_len pulse; no core_start; next clean 10-word block starts normally.
- 10 words with no s_last -> err_len on word 9; fill_cnt=0; s_ready stays 1.
- rst_n low after 5 words and during RUN -> all outputs zero, s_ready=1; next core_done ignored, blk_cnt=0.
- Back-to-back blocks with s_valid held high and core_done 20 cycles after each core_start -> 16 blocks start in order; blk_cnt=16; no word lost or duplicated.
